pipe_stage_buf: RTL and testbench

- Parametrised inter-stage pipeline buffer (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a valid bit, a PC and a DATA_W-bit payload.
- Uses the full valid / ready_go / allowin handshake and a pipeline flush.
- Optional 2-entry skid mode (SKID=1) registers in_allowin, breaking the combinational allowin chain between stages.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_stage_buf.sv | 159 +++++++++++++++
 tb/tb_pipe_stage_buf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline buffers.
package pipe_pkg;

    localparam logic [31:0] PC_RESET      = 32'h1bfffffc;
    localparam int          SLOT_DATA_MAX = 512;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              pc;
        logic [SLOT_DATA_MAX-1:0] data;
    } pipe_slot_t;

    function automatic logic [1:0] slot_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One buffer entry (valid/pc/data) with load, clear and drop controls.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = PC_RESET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              drop,
    input  logic [31:0]       d_pc,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [31:0]       pc,
    output logic [DATA_W-1:0] data
);

    // Clear wins over load; drop only lowers valid so pc/data keep their last values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            pc    <= RESET_PC;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= d_pc;
            data  <= d_data;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer with valid/ready_go/allowin handshake, flush,
// and an optional skid slot that registers in_allowin.
//
// state | meaning
// EMPTY | no entry held
// ONE   | main slot valid, skid slot empty
// FULL  | main and skid slots valid, upstream blocked
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = PC_RESET,
    parameter int          SKID     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_allowin,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              stage_ready_go,
    input  logic              next_allowin,
    output logic              out_valid,
    output logic              to_next_valid,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              accept;
    logic              drain;
    logic              main_valid;
    logic [31:0]       main_pc;
    logic [DATA_W-1:0] main_data;

    assign accept        = in_valid && in_allowin;
    assign to_next_valid = main_valid && stage_ready_go;
    assign drain         = to_next_valid && next_allowin;
    assign out_valid     = main_valid;
    assign out_pc        = main_pc;
    assign out_data      = main_data;

    generate
        if (SKID == 0) begin : g_single
            assign in_allowin = !main_valid || (stage_ready_go && next_allowin);
            assign occupancy  = slot_count(main_valid, 1'b0);

            pipe_slot #(.DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_main (
                .clk    (clk),
                .rst    (rst),
                .clear  (flush),
                .load   (accept),
                .drop   (drain),
                .d_pc   (in_pc),
                .d_data (in_data),
                .valid  (main_valid),
                .pc     (main_pc),
                .data   (main_data)
            );
        end else begin : g_skid
            pipe_state_t       state_q;
            pipe_state_t       state_d;
            logic              main_load;
            logic              main_from_skid;
            logic              main_drop;
            logic              skid_load;
            logic              skid_drop;
            logic              skid_valid;
            logic [31:0]       skid_pc;
            logic [DATA_W-1:0] skid_data;
            logic [31:0]       main_d_pc;
            logic [DATA_W-1:0] main_d_data;

            always_ff @(posedge clk) begin
                if (rst || flush) state_q <= EMPTY;
                else              state_q <= state_d;
            end

            always_comb begin
                state_d = state_q;
                case (state_q)
                    EMPTY: if (accept) state_d = ONE;
                    ONE: begin
                        if (accept && !drain)      state_d = FULL;
                        else if (!accept && drain) state_d = EMPTY;
                    end
                    FULL:    if (drain) state_d = ONE;
                    default: state_d = EMPTY;
                endcase
            end

            // FULL drain refills the main slot from the skid slot in the same cycle.
            always_comb begin
                main_load      = 1'b0;
                main_from_skid = 1'b0;
                main_drop      = 1'b0;
                skid_load      = 1'b0;
                skid_drop      = 1'b0;
                case (state_q)
                    EMPTY: main_load = accept;
                    ONE: begin
                        main_load = accept && drain;
                        skid_load = accept && !drain;
                        main_drop = drain && !accept;
                    end
                    FULL: begin
                        main_load      = drain;
                        main_from_skid = drain;
                        skid_drop      = drain;
                    end
                    default: ;
                endcase
            end

            // Depends on the state register only, never on next_allowin.
            assign in_allowin  = (state_q != FULL);
            assign occupancy   = slot_count(main_valid, skid_valid);
            assign main_d_pc   = main_from_skid ? skid_pc   : in_pc;
            assign main_d_data = main_from_skid ? skid_data : in_data;

            pipe_slot #(.DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_main (
                .clk    (clk),
                .rst    (rst),
                .clear  (flush),
                .load   (main_load),
                .drop   (main_drop),
                .d_pc   (main_d_pc),
                .d_data (main_d_data),
                .valid  (main_valid),
                .pc     (main_pc),
                .data   (main_data)
            );

            pipe_slot #(.DATA_W(DATA_W), .RESET_PC(RESET_PC)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .clear  (flush),
                .load   (skid_load),
                .drop   (skid_drop),
                .d_pc   (in_pc),
                .d_data (in_data),
                .valid  (skid_valid),
                .pc     (skid_pc),
                .data   (skid_data)
            );
        end
    endgenerate

    a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({in_valid, stage_ready_go}));

    a_tnv_implies_valid: assert property (@(posedge clk)
        to_next_valid |-> out_valid);

    a_head_stable: assert property (@(posedge clk) disable iff (rst || flush)
        (out_valid && !drain) |=> ($stable(out_pc) && $stable(out_data)));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_buf;

    localparam logic [31:0] RST_PC = 32'h1bfffffc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic        a_in_valid = 0, a_flush = 0, a_srg = 0, a_na = 0;
    logic [31:0] a_in_pc = 0, a_in_data = 0;
    logic        a_allowin, a_out_valid, a_tnv;
    logic [31:0] a_out_pc, a_out_data;
    logic [1:0]  a_occ;

    logic         b_in_valid = 0, b_flush = 0, b_srg = 0, b_na = 0;
    logic [31:0]  b_in_pc = 0;
    logic [127:0] b_in_data = 0;
    logic         b_allowin, b_out_valid, b_tnv;
    logic [31:0]  b_out_pc;
    logic [127:0] b_out_data;
    logic [1:0]   b_occ;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(32), .RESET_PC(RST_PC), .SKID(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_allowin(a_allowin),
        .in_pc(a_in_pc), .in_data(a_in_data), .flush(a_flush),
        .stage_ready_go(a_srg), .next_allowin(a_na), .out_valid(a_out_valid),
        .to_next_valid(a_tnv), .out_pc(a_out_pc), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_buf #(.DATA_W(128), .RESET_PC(RST_PC), .SKID(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_allowin(b_allowin),
        .in_pc(b_in_pc), .in_data(b_in_data), .flush(b_flush),
        .stage_ready_go(b_srg), .next_allowin(b_na), .out_valid(b_out_valid),
        .to_next_valid(b_tnv), .out_pc(b_out_pc), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_a_valid got %0b want 0", a_out_valid); end
        tests++; if (a_out_pc !== RST_PC) begin fails++; $display("FAIL reset_a_pc got %h want %h", a_out_pc, RST_PC); end
        tests++; if (a_out_data !== 32'h0) begin fails++; $display("FAIL reset_a_data got %h want 0", a_out_data); end
        tests++; if (a_occ !== 2'd0) begin fails++; $display("FAIL reset_a_occ got %0d want 0", a_occ); end
        tests++; if (a_allowin !== 1'b1) begin fails++; $display("FAIL reset_a_allowin got %0b want 1", a_allowin); end
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL reset_b_valid got %0b want 0", b_out_valid); end
        tests++; if (b_out_pc !== RST_PC) begin fails++; $display("FAIL reset_b_pc got %h want %h", b_out_pc, RST_PC); end
        tests++; if (b_out_data !== 128'h0) begin fails++; $display("FAIL reset_b_data got %h want 0", b_out_data); end
        tests++; if (b_occ !== 2'd0) begin fails++; $display("FAIL reset_b_occ got %0d want 0", b_occ); end
        tests++; if (b_allowin !== 1'b1) begin fails++; $display("FAIL reset_b_allowin got %0b want 1", b_allowin); end
    endtask

    task automatic test_pass_through();
        a_in_valid = 1; a_in_pc = 32'h1c000000; a_in_data = 32'h02800c05; a_srg = 1; a_na = 1;
        tick();
        a_in_valid = 0;
        #1;
        tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL pass_valid got %0b want 1", a_out_valid); end
        tests++; if (a_out_pc !== 32'h1c000000) begin fails++; $display("FAIL pass_pc got %h want 1c000000", a_out_pc); end
        tests++; if (a_out_data !== 32'h02800c05) begin fails++; $display("FAIL pass_data got %h want 02800c05", a_out_data); end
        tests++; if (a_allowin !== 1'b1) begin fails++; $display("FAIL pass_allowin got %0b want 1", a_allowin); end
        tests++; if (a_tnv !== 1'b1) begin fails++; $display("FAIL pass_tnv got %0b want 1", a_tnv); end
        tick();
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL pass_drained got %0b want 0", a_out_valid); end
        tests++; if (a_out_pc !== 32'h1c000000) begin fails++; $display("FAIL pass_pc_hold got %h want 1c000000", a_out_pc); end
    endtask

    task automatic test_stall();
        a_in_valid = 1; a_in_pc = 32'h1c000004; a_in_data = 32'h0badf00d; a_srg = 1; a_na = 1;
        tick();
        a_in_pc = 32'h1c000008; a_in_data = 32'h11111111; a_na = 0;
        repeat (3) begin
            #1;
            tests++; if (a_allowin !== 1'b0) begin fails++; $display("FAIL stall_allowin got %0b want 0", a_allowin); end
            tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid got %0b want 1", a_out_valid); end
            tests++; if (a_out_pc !== 32'h1c000004) begin fails++; $display("FAIL stall_pc got %h want 1c000004", a_out_pc); end
            tests++; if (a_out_data !== 32'h0badf00d) begin fails++; $display("FAIL stall_data got %h want 0badf00d", a_out_data); end
            tick();
        end
        a_na = 1; a_in_valid = 0;
        #1;
        tests++; if (a_allowin !== 1'b1) begin fails++; $display("FAIL stall_release_allowin got %0b want 1", a_allowin); end
        tick();
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL stall_release_drain got %0b want 0", a_out_valid); end
    endtask

    task automatic test_ready_go();
        a_in_valid = 1; a_in_pc = 32'h1c00000c; a_in_data = 32'h12345678; a_srg = 1; a_na = 1;
        tick();
        a_in_valid = 0; a_srg = 0;
        #1;
        tests++; if (a_tnv !== 1'b0) begin fails++; $display("FAIL rg_tnv_low got %0b want 0", a_tnv); end
        tests++; if (a_allowin !== 1'b0) begin fails++; $display("FAIL rg_allowin got %0b want 0", a_allowin); end
        tick();
        tests++; if (a_out_valid !== 1'b1 || a_out_pc !== 32'h1c00000c) begin fails++; $display("FAIL rg_hold got %0b/%h want 1/1c00000c", a_out_valid, a_out_pc); end
        a_srg = 1;
        #1;
        tests++; if (a_tnv !== 1'b1) begin fails++; $display("FAIL rg_tnv_high got %0b want 1", a_tnv); end
        tick();
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL rg_drain got %0b want 0", a_out_valid); end
    endtask

    task automatic test_flush_single();
        a_in_valid = 1; a_in_pc = 32'h1c000010; a_in_data = 32'hffff0000; a_flush = 1;
        tick();
        a_flush = 0; a_in_valid = 0;
        #1;
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL flush_a_valid got %0b want 0", a_out_valid); end
        tests++; if (a_out_pc !== RST_PC) begin fails++; $display("FAIL flush_a_pc got %h want %h", a_out_pc, RST_PC); end
        tests++; if (a_out_data !== 32'h0) begin fails++; $display("FAIL flush_a_data got %h want 0", a_out_data); end
    endtask

    task automatic test_skid_fill();
        b_srg = 1; b_na = 1; b_in_valid = 1;
        b_in_pc = 32'h1c000000; b_in_data = {4{32'h1c000000}};
        tick();
        b_in_pc = 32'h1c000004; b_in_data = {4{32'h1c000004}}; b_na = 0;
        tick();
        tests++; if (b_occ !== 2'd2) begin fails++; $display("FAIL skid_occ_full got %0d want 2", b_occ); end
        tests++; if (b_allowin !== 1'b0) begin fails++; $display("FAIL skid_allowin got %0b want 0", b_allowin); end
        tests++; if (b_out_pc !== 32'h1c000000) begin fails++; $display("FAIL skid_head got %h want 1c000000", b_out_pc); end
        b_in_pc = 32'h1c000008; b_in_data = {4{32'h1c000008}};
        tick();
        tests++; if (b_occ !== 2'd2 || b_out_pc !== 32'h1c000000) begin fails++; $display("FAIL skid_blocked got %0d/%h want 2/1c000000", b_occ, b_out_pc); end
        b_in_valid = 0; b_na = 1;
        tick();
        tests++; if (b_out_pc !== 32'h1c000004) begin fails++; $display("FAIL skid_second_pc got %h want 1c000004", b_out_pc); end
        tests++; if (b_out_data !== {4{32'h1c000004}}) begin fails++; $display("FAIL skid_second_data got %h want %h", b_out_data, {4{32'h1c000004}}); end
        tests++; if (b_occ !== 2'd1 || b_allowin !== 1'b1) begin fails++; $display("FAIL skid_after_drain got occ %0d allowin %0b want 1/1", b_occ, b_allowin); end
        tick();
        tests++; if (b_occ !== 2'd0 || b_out_valid !== 1'b0) begin fails++; $display("FAIL skid_empty got occ %0d valid %0b want 0/0", b_occ, b_out_valid); end
    endtask

    task automatic test_flush_priority();
        b_srg = 1; b_na = 1; b_in_valid = 1;
        b_in_pc = 32'h1c000020; b_in_data = {4{32'haaaa5555}};
        tick();
        b_in_pc = 32'h1c000024; b_na = 0;
        tick();
        b_in_pc = 32'h1c000010; b_flush = 1;
        tick();
        b_flush = 0; b_in_valid = 0;
        #1;
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL flush_b_valid got %0b want 0", b_out_valid); end
        tests++; if (b_occ !== 2'd0) begin fails++; $display("FAIL flush_b_occ got %0d want 0", b_occ); end
        tests++; if (b_out_pc !== RST_PC) begin fails++; $display("FAIL flush_b_pc got %h want %h", b_out_pc, RST_PC); end
        tests++; if (b_out_data !== 128'h0) begin fails++; $display("FAIL flush_b_data got %h want 0", b_out_data); end
        tests++; if (b_allowin !== 1'b1) begin fails++; $display("FAIL flush_b_allowin got %0b want 1", b_allowin); end
        b_flush = 1; b_in_valid = 1; b_na = 0;
        repeat (3) begin
            tick();
            tests++; if (b_occ !== 2'd0) begin fails++; $display("FAIL flush_hold_occ got %0d want 0", b_occ); end
        end
        b_flush = 0; b_in_valid = 0;
    endtask

    task automatic test_random();
        logic [63:0]  qa[$];
        logic [159:0] qb[$];
        logic [63:0]  held_a, exp_a;
        logic [159:0] held_b, exp_b;
        logic         exp_av, exp_aall, exp_bv, exp_ball, acc, drn;
        a_flush = 1; b_flush = 1;
        tick();
        held_a = {RST_PC, 32'h0};
        held_b = {RST_PC, 128'h0};
        for (int cyc = 0; cyc < 10000; cyc++) begin
            a_in_valid = ($urandom_range(3) != 0);
            a_srg      = ($urandom_range(3) != 0);
            a_na       = ($urandom_range(2) != 0);
            a_flush    = ($urandom_range(63) == 0);
            a_in_pc    = $urandom;
            a_in_data  = $urandom;
            b_in_valid = ($urandom_range(3) != 0);
            b_srg      = ($urandom_range(3) != 0);
            b_na       = ($urandom_range(2) != 0);
            b_flush    = ($urandom_range(63) == 0);
            b_in_pc    = $urandom;
            b_in_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            exp_av   = (qa.size() != 0);
            exp_a    = exp_av ? qa[0] : held_a;
            exp_aall = !exp_av || (a_srg && a_na);
            exp_bv   = (qb.size() != 0);
            exp_b    = exp_bv ? qb[0] : held_b;
            exp_ball = (qb.size() < 2);
            tests++; if (a_out_valid !== exp_av) begin fails++; $display("FAIL rnd_a_valid cyc %0d got %0b want %0b", cyc, a_out_valid, exp_av); end
            tests++; if ({a_out_pc, a_out_data} !== exp_a) begin fails++; $display("FAIL rnd_a_head cyc %0d got %h want %h", cyc, {a_out_pc, a_out_data}, exp_a); end
            tests++; if (a_allowin !== exp_aall) begin fails++; $display("FAIL rnd_a_allowin cyc %0d got %0b want %0b", cyc, a_allowin, exp_aall); end
            tests++; if (a_occ !== 2'(qa.size())) begin fails++; $display("FAIL rnd_a_occ cyc %0d got %0d want %0d", cyc, a_occ, qa.size()); end
            tests++; if (a_tnv !== (exp_av && a_srg)) begin fails++; $display("FAIL rnd_a_tnv cyc %0d got %0b want %0b", cyc, a_tnv, exp_av && a_srg); end
            tests++; if (b_out_valid !== exp_bv) begin fails++; $display("FAIL rnd_b_valid cyc %0d got %0b want %0b", cyc, b_out_valid, exp_bv); end
            tests++; if ({b_out_pc, b_out_data} !== exp_b) begin fails++; $display("FAIL rnd_b_head cyc %0d got %h want %h", cyc, {b_out_pc, b_out_data}, exp_b); end
            tests++; if (b_allowin !== exp_ball) begin fails++; $display("FAIL rnd_b_allowin cyc %0d got %0b want %0b", cyc, b_allowin, exp_ball); end
            tests++; if (b_occ !== 2'(qb.size())) begin fails++; $display("FAIL rnd_b_occ cyc %0d got %0d want %0d", cyc, b_occ, qb.size()); end
            tests++; if (b_tnv !== (exp_bv && b_srg)) begin fails++; $display("FAIL rnd_b_tnv cyc %0d got %0b want %0b", cyc, b_tnv, exp_bv && b_srg); end
            // Wiggling next_allowin mid-cycle must not move the skid buffer's allowin.
            b_na = !b_na;
            #1;
            tests++; if (b_allowin !== exp_ball) begin fails++; $display("FAIL rnd_b_allowin_comb cyc %0d got %0b want %0b", cyc, b_allowin, exp_ball); end
            b_na = !b_na;
            #1;
            acc = a_in_valid && exp_aall;
            drn = exp_av && a_srg && a_na;
            if (a_flush) begin
                qa.delete();
                held_a = {RST_PC, 32'h0};
            end else begin
                if (drn) held_a = qa.pop_front();
                if (acc) qa.push_back({a_in_pc, a_in_data});
            end
            acc = b_in_valid && exp_ball;
            drn = exp_bv && b_srg && b_na;
            if (b_flush) begin
                qb.delete();
                held_b = {RST_PC, 128'h0};
            end else begin
                if (drn) held_b = qb.pop_front();
                if (acc) qb.push_back({b_in_pc, b_in_data});
            end
            tick();
        end
        a_flush = 0; b_flush = 0;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall();
        test_ready_go();
        test_flush_single();
        test_skid_fill();
        test_flush_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
